// File: rtl/sock_batch_counter.sv
// sock_batch_counter: counts qualified sock presentations of one product and
// raises a pack request each time BATCH of them have been collected.
// Ports:
//   clk    - system clock, all state on the rising edge
//   reset  - asynchronous active-low reset
//   PH     - sock present at station (level; counted on its rising edge)
//   SR     - sock ready / quality pass
//   T      - sock type code, must equal T_CODE to count
//   PLS    - sock size code, must equal PLS_CODE to count
//   CLR    - synchronous clear of the current batch (TOTAL kept)
//   ACK    - packer acknowledges the pending pack
//   LED    - socks in the current batch
//   PAC    - PAC_CODE while a pack is pending, else 0
//   CO     - pack pending
//   OVF    - sticky: a qualified sock arrived while a pack was pending
//   TOTAL  - completed batches, wraps silently
module sock_batch_counter #(
  parameter int         CNT_W    = 4,
  parameter int         BATCH    = 7,
  parameter logic [2:0] T_CODE   = 3'b100,
  parameter logic [1:0] PLS_CODE = 2'b10,
  parameter logic [2:0] PAC_CODE = 3'b011,
  parameter int         TOT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             PH,
  input  logic             SR,
  input  logic [2:0]       T,
  input  logic [1:0]       PLS,
  input  logic             CLR,
  input  logic             ACK,
  output logic [CNT_W-1:0] LED,
  output logic [2:0]       PAC,
  output logic             CO,
  output logic             OVF,
  output logic [TOT_W-1:0] TOTAL
);
  typedef enum logic {COUNT, FULL} state_t;
  state_t           st_q, st_d;
  logic [CNT_W-1:0] led_q, led_d;
  logic [TOT_W-1:0] tot_q, tot_d;
  logic             ovf_q, ovf_d, ph_q, co_q, ev;
  logic [2:0]       pac_q;
  assign ev = PH & ~ph_q & SR & (T == T_CODE) & (PLS == PLS_CODE);
  always_comb begin
    st_d  = st_q;
    led_d = led_q;
    tot_d = tot_q;
    ovf_d = ovf_q;
    if (CLR) begin
      st_d  = COUNT;
      led_d = '0;
      ovf_d = 1'b0;
    end else if (st_q == COUNT) begin
      if (ev) begin
        led_d = led_q + 1'b1;
        st_d  = (led_q == CNT_W'(BATCH - 1)) ? FULL : COUNT;
      end
    end else if (ACK) begin
      // A sock arriving with the ACK opens the next batch; with BATCH==1 it fills it.
      tot_d = tot_q + 1'b1;
      led_d = ev ? CNT_W'(1) : '0;
      st_d  = (ev && BATCH == 1) ? FULL : COUNT;
    end else if (ev) begin
      ovf_d = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q  <= COUNT;
      led_q <= '0;
      tot_q <= '0;
      ovf_q <= 1'b0;
      ph_q  <= 1'b1;
      co_q  <= 1'b0;
      pac_q <= '0;
    end else begin
      st_q  <= st_d;
      led_q <= led_d;
      tot_q <= tot_d;
      ovf_q <= ovf_d;
      ph_q  <= PH;
      co_q  <= (st_d == FULL);
      pac_q <= (st_d == FULL) ? PAC_CODE : 3'b000;
    end
  end
  assign LED   = led_q;
  assign PAC   = pac_q;
  assign CO    = co_q;
  assign OVF   = ovf_q;
  assign TOTAL = tot_q;
endmodule

// File: tb/tb_sock_batch_counter.sv
// tb_sock_batch_counter: directed self-checking bench for sock_batch_counter.
module tb_sock_batch_counter;
  logic       clk = 0, reset = 0, PH = 0, SR = 0, CLR = 0, ACK = 0;
  logic [2:0] T = 0;
  logic [1:0] PLS = 0;
  logic [3:0] led0, led1, led2;
  logic [2:0] pac0, pac1, pac2;
  logic       co0, co1, co2, ovf0, ovf1, ovf2;
  logic [7:0] tot0, tot1;
  logic [1:0] tot2;
  int ncmp = 0, nerr = 0;
  always #5 clk = ~clk;
  sock_batch_counter dut (.clk(clk), .reset(reset), .PH(PH), .SR(SR), .T(T), .PLS(PLS),
    .CLR(CLR), .ACK(ACK), .LED(led0), .PAC(pac0), .CO(co0), .OVF(ovf0), .TOTAL(tot0));
  sock_batch_counter #(.BATCH(1)) dut1 (.clk(clk), .reset(reset), .PH(PH), .SR(SR), .T(T), .PLS(PLS),
    .CLR(CLR), .ACK(ACK), .LED(led1), .PAC(pac1), .CO(co1), .OVF(ovf1), .TOTAL(tot1));
  sock_batch_counter #(.BATCH(1), .TOT_W(2)) dut2 (.clk(clk), .reset(reset), .PH(PH), .SR(SR), .T(T), .PLS(PLS),
    .CLR(CLR), .ACK(ACK), .LED(led2), .PAC(pac2), .CO(co2), .OVF(ovf2), .TOTAL(tot2));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic pulse(input logic sr, input logic [2:0] t, input logic [1:0] pls, input int hi, input int lo);
    SR = sr; T = t; PLS = pls; PH = 1;
    repeat (hi) tick();
    PH = 0;
    repeat (lo) tick();
  endtask
  task automatic do_reset();
    reset = 0;
    #3;
    reset = 1;
    tick();
  endtask
  logic [1:0] wrap_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
  initial begin
    tick();
    chk("rst_led", led0, 0); chk("rst_co", co0, 0); chk("rst_pac", pac0, 0);
    chk("rst_ovf", ovf0, 0); chk("rst_tot", tot0, 0);
    reset = 1;
    tick();
    for (int i = 1; i <= 7; i++) begin
      pulse(1, 3'b100, 2'b10, 2, 2);
      chk($sformatf("cnt_led%0d", i), led0, i);
      if (i < 7) chk($sformatf("cnt_co%0d", i), co0, 0);
    end
    chk("full_co", co0, 1); chk("full_pac", pac0, 3'b011); chk("full_tot", tot0, 0);
    ACK = 1; tick(); ACK = 0;
    chk("ack_led", led0, 0); chk("ack_co", co0, 0); chk("ack_pac", pac0, 0); chk("ack_tot", tot0, 1);
    pulse(1, 3'b010, 2'b10, 2, 2); chk("q_type", led0, 0);
    pulse(1, 3'b100, 2'b01, 2, 2); chk("q_size", led0, 0);
    pulse(0, 3'b100, 2'b10, 2, 2); chk("q_sr", led0, 0);
    pulse(1, 3'b100, 2'b10, 10, 2); chk("q_held", led0, 1);
    repeat (6) pulse(1, 3'b100, 2'b10, 1, 1);
    chk("drop_fill_led", led0, 7); chk("drop_fill_co", co0, 1);
    repeat (2) pulse(1, 3'b100, 2'b10, 1, 1);
    chk("drop_led", led0, 7); chk("drop_ovf", ovf0, 1); chk("drop_tot", tot0, 1);
    ACK = 1; tick(); ACK = 0;
    chk("drop_ack_led", led0, 0); chk("drop_ack_ovf", ovf0, 1); chk("drop_ack_tot", tot0, 2);
    CLR = 1; tick(); CLR = 0;
    chk("clr_ovf", ovf0, 0);
    repeat (7) pulse(1, 3'b100, 2'b10, 1, 1);
    chk("sim_full_co", co0, 1);
    PH = 1; ACK = 1; tick(); ACK = 0; PH = 0;
    chk("sim_led", led0, 1); chk("sim_co", co0, 0); chk("sim_tot", tot0, 3); chk("sim_ovf", ovf0, 0);
    tick();
    repeat (4) pulse(1, 3'b100, 2'b10, 1, 1);
    chk("clr5_led", led0, 5);
    CLR = 1; tick(); CLR = 0;
    chk("clr5_led0", led0, 0); chk("clr5_tot", tot0, 3);
    repeat (4) pulse(1, 3'b100, 2'b10, 1, 1);
    chk("mid_led", led0, 4);
    #3; reset = 0; #1;
    chk("async_led", led0, 0); chk("async_tot", tot0, 0); chk("async_co", co0, 0);
    PH = 1;
    tick();
    reset = 1;
    tick(); tick();
    chk("held_rel_led", led0, 0);
    PH = 0; tick();
    pulse(1, 3'b100, 2'b10, 1, 1);
    chk("pre_clr_led", led0, 1);
    PH = 1; CLR = 1; tick(); CLR = 0; PH = 0;
    chk("clr_ev_led", led0, 0);
    tick();
    do_reset();
    pulse(1, 3'b100, 2'b10, 1, 1);
    chk("b1_led", led1, 1); chk("b1_co", co1, 1); chk("b1_pac", pac1, 3'b011);
    PH = 1; ACK = 1; tick(); ACK = 0; PH = 0;
    chk("b1_sim_led", led1, 1); chk("b1_sim_co", co1, 1); chk("b1_sim_tot", tot1, 1);
    tick();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      pulse(1, 3'b100, 2'b10, 1, 1);
      ACK = 1; tick(); ACK = 0;
      chk($sformatf("wrap%0d", i), tot2, wrap_exp[i]);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
